hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
// - Multi-cycle multiply/divide engine and HI/LO architectural register pair; sits beside the execute-stage ALU.
// - Takes the same Data1/Data2 operands the ALU gets and produces the HI/LO values read by MFHI/MFLO.
// - Iterative: one result bit per cycle. busy stalls the pipeline until HI/LO are final.
// PARAMETERS
// - WIDTH  32  operand width; HI and LO are WIDTH bits each; the product is 2*WIDTH.
// PORTS
// - clk        in   1      rising-edge clock
// - reset_n    in   1      asynchronous active-low reset
// - op         in   3      muldiv_pkg::md_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
// - op_valid   in   1      op/Data1/Data2 valid this cycle
// - op_ready   out  1      ==!busy; the op is accepted only when op_valid&&op_ready
// - flush      in   1      cancel the in-flight op (branch/exception squash)
// - Data1      in   WIDTH  rs: multiplicand/dividend; MTHI/MTLO source
// - Data2      in   WIDTH  rt: multiplier/divisor
// - busy       out  1      iteration in progress
// - done       out  1      one-cycle pulse after HI/LO are written by a mult/div
// - HI         out  WIDTH  registered HI
// - LO         out  WIDTH  registered LO
// BEHAVIOUR
// - Reset (async, any state): HI=LO=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation drops the op.
// - States: IDLE, RUN_MUL, RUN_DIV. Counter width $clog2(WIDTH)+1.
// - IDLE: on an accepted MULT/MULTU go to RUN_MUL; on DIV/DIVU go to RUN_DIV.
//   - Latch |operand| for signed ops (raw operand for unsigned ops), the result sign, and the dividend sign; counter=0.
// - RUN_*: one iteration per cycle (shift-add multiply, restoring divide).
//   - After WIDTH iterations, write HI/LO at that edge with sign correction applied and return to IDLE.
//   - done=1 for the next cycle. Total: accept edge E0, write edge E0+WIDTH, busy high for exactly WIDTH cycles.
// - MULT/MULTU: HI=product[2W-1:W], LO=product[W-1:0]; two's-complement result for signed ops.
// - DIV/DIVU: LO=quotient, HI=remainder.
//   - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
//   - Signed MIN/-1: LO=MIN, HI=0 (natural wrap, no trap).
// - Divide by zero (either signedness): still runs WIDTH cycles; LO=all ones, HI=Data1 as latched (raw, unsigned view).
// - MTHI/MTLO: accepted only in IDLE; write HI/LO at the next edge; single-cycle; no busy, no done.
// - NONE, or op_valid while busy: ignored; HI/LO and state unchanged.
// - flush: in RUN_*, return to IDLE next edge; HI/LO unchanged, no done. In IDLE, flush has priority over a simultaneous accepted op (op dropped).
// - HI/LO change only at a final-iteration edge, an MTHI/MTLO edge, or reset.
// CONFIGURATION
// - MULDIV_DIV0_FLAG_EN defined: adds output div0 (1 bit, reset 0).
//   - Set with the done pulse of a zero-divisor DIV/DIVU; cleared by the next accepted op.
// - Undefined: no div0 port; results are the same.
// STRUCTURE
// - muldiv_pkg: md_op_t enum (3 bits), md_state_t enum, MD_DIV0_QUOT constant (all ones).
// - Sub-module restoring_div_core: unsigned one-bit-per-cycle divide step (remainder/quotient shift, trial subtract).
//   - The sign pre/post-processing and the multiplier stay in hilo_muldiv_unit.
// TESTING
// - MULT Data1=FFFFFFFD(-3), Data2=00000005 -> busy 32 cycles, then done; HI=FFFFFFFF, LO=FFFFFFF1.
// - MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001. MULT of the same operands -> HI=0, LO=1.
// - DIV FFFFFFF9(-7)/00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
//   - DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
// - DIVU 7/0 -> LO=FFFFFFFF, HI=00000007; with MULDIV_DIV0_FLAG_EN, div0=1 alongside done.
// - MTHI 12345678 then MULTU 2*3 issued while busy is ignored.
//   - Flush at cycle 10 of a DIV -> IDLE next cycle, no done, HI=12345678, LO unchanged.
// - reset_n low at cycle 5 of a MULT -> HI=LO=0, busy=0 immediately.
//   - After release, MTLO AAAA5555 -> LO=AAAA5555 next edge, op_ready stays 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Holds the operation encoding, the engine state encoding and the
// quotient value produced by a divide with a zero divisor.
package muldiv_pkg;

    // Operation requested alongside Data1/Data2
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    // Engine sequencing state
    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_RUN_MUL = 2'd1,
        MD_RUN_DIV = 2'd2
    } md_state_t;

    // Widest operand the unit is built for; the zero-divisor quotient is sliced from this
    localparam int MD_MAX_WIDTH = 64;

    // Quotient written to LO when the divisor is zero (all ones at any width)
    localparam logic [MD_MAX_WIDTH-1:0] MD_DIV0_QUOT = '1;

    // Signed variants need magnitude conversion on entry and sign fix-up on exit
    function automatic logic isSignedOp(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/restoring_div_core.sv
// One iteration of an unsigned restoring divide.
// The partial remainder is shifted left by one, pulling in the next dividend
// bit from the top of the quotient register; a trial subtraction of the
// divisor decides the new quotient bit, which enters at the bottom.
module restoring_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;

    // Shift the next dividend bit in, then keep the difference only if it did not go negative
    always_comb begin
        w_shifted = {i_rem, i_quo[WIDTH-1]};
        if (w_shifted >= {1'b0, i_divisor}) begin
            o_rem = w_shifted[WIDTH-1:0] - i_divisor;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shifted[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine with the HI/LO architectural registers.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage; mult/div run
// for WIDTH cycles (one result bit per cycle) while busy stalls the pipeline.
// Optional build macro: MULDIV_DIV0_FLAG_EN adds the div0 output, which rises
// with the done pulse of a zero-divisor divide.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  md_op_t           op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_accHi;
    logic [WIDTH-1:0]   r_accLo;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   r_rawA;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_opSigned;
    logic               w_lastIter;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH-1:0]   w_mulHiNext;
    logic [WIDTH-1:0]   w_mulLoNext;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_productFinal;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;
    logic [WIDTH-1:0]   w_quoFinal;
    logic [WIDTH-1:0]   w_remFinal;

    // Magnitude of an operand when the op is signed; unsigned ops use the raw bits
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign op_ready   = !r_busy;
    assign busy       = r_busy;
    assign done       = r_done;
    assign HI         = r_hi;
    assign LO         = r_lo;

    assign w_accept   = op_valid && (r_state == MD_IDLE) && !flush;
    assign w_opSigned = isSignedOp(op);
    assign w_lastIter = (r_count == CW'(WIDTH - 1));

    // Shift-add multiply step: conditionally add the multiplicand into the upper half, then shift right
    always_comb begin
        w_mulSum    = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : {(WIDTH+1){1'b0}});
        w_mulHiNext = w_mulSum[WIDTH:1];
        w_mulLoNext = {w_mulSum[0], r_accLo[WIDTH-1:1]};
        w_product   = {w_mulHiNext, w_mulLoNext};
        w_productFinal = r_negRes ? (~w_product + 1'b1) : w_product;
    end

    restoring_div_core #(
        .WIDTH     (WIDTH)
    ) u_divCore (
        .i_rem     (r_accHi),
        .i_quo     (r_accLo),
        .i_divisor (r_opB),
        .o_rem     (w_remNext),
        .o_quo     (w_quoNext)
    );

    // Sign correction of the final divide step, with the zero-divisor result taking precedence
    always_comb begin
        if (r_divZero) begin
            w_quoFinal = MD_DIV0_QUOT[WIDTH-1:0];
            w_remFinal = r_rawA;
        end else begin
            w_quoFinal = r_negRes ? (~w_quoNext + 1'b1) : w_quoNext;
            w_remFinal = r_negRem ? (~w_remNext + 1'b1) : w_remNext;
        end
    end

    // Sequencer: accepts ops in IDLE, iterates WIDTH times, commits HI/LO and pulses done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= MD_IDLE;
            r_count   <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_opB     <= '0;
            r_rawA    <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                r_state   <= MD_RUN_MUL;
                                r_busy    <= 1'b1;
                                r_count   <= '0;
                                r_accHi   <= '0;
                                r_accLo   <= absVal(Data2, w_opSigned);
                                r_opB     <= absVal(Data1, w_opSigned);
                                r_negRes  <= w_opSigned && (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
                                r_negRem  <= 1'b0;
                                r_divZero <= 1'b0;
                                r_rawA    <= Data1;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_state   <= MD_RUN_DIV;
                                r_busy    <= 1'b1;
                                r_count   <= '0;
                                r_accHi   <= '0;
                                r_accLo   <= absVal(Data1, w_opSigned);
                                r_opB     <= absVal(Data2, w_opSigned);
                                r_negRes  <= w_opSigned && (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
                                r_negRem  <= w_opSigned && Data1[WIDTH-1];
                                r_divZero <= (Data2 == '0);
                                r_rawA    <= Data1;
                            end
                            MD_MTHI: r_hi <= Data1;
                            MD_MTLO: r_lo <= Data1;
                            default: ;
                        endcase
                    end
                end
                MD_RUN_MUL: begin
                    if (flush) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (w_lastIter) begin
                        r_hi    <= w_productFinal[2*WIDTH-1:WIDTH];
                        r_lo    <= w_productFinal[WIDTH-1:0];
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_accHi <= w_mulHiNext;
                        r_accLo <= w_mulLoNext;
                        r_count <= r_count + CW'(1);
                    end
                end
                MD_RUN_DIV: begin
                    if (flush) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (w_lastIter) begin
                        r_hi    <= w_remFinal;
                        r_lo    <= w_quoFinal;
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_accHi <= w_remNext;
                        r_accLo <= w_quoNext;
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

`ifdef MULDIV_DIV0_FLAG_EN
    logic r_div0;

    assign div0 = r_div0;

    // Zero-divisor flag: raised with the done pulse of such a divide, dropped by the next accepted op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div0 <= 1'b0;
        end else if ((r_state == MD_RUN_DIV) && !flush && w_lastIter) begin
            r_div0 <= r_divZero;
        end else if (w_accept && (op != MD_NONE)) begin
            r_div0 <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases from the
// datasheet examples followed by randomized mult/div/move traffic, all
// compared with an arithmetic model of HI/LO kept in the bench.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    md_op_t       op = MD_NONE;
    logic         op_valid = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] Data1 = '0;
    logic [W-1:0] Data2 = '0;
    logic         op_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
`ifdef MULDIV_DIV0_FLAG_EN
    logic         div0;
`endif

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;

    hilo_muldiv_unit #(
        .WIDTH    (W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .flush    (flush),
        .Data1    (Data1),
        .Data2    (Data2),
        .busy     (busy),
        .done     (done),
`ifdef MULDIV_DIV0_FLAG_EN
        .div0     (div0),
`endif
        .HI       (HI),
        .LO       (LO)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op, computed with plain integer arithmetic
    task automatic modelOp(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MD_MULT: begin
                p = sa * sb;
                mHi = p[63:32];
                mLo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                mHi = p[63:32];
                mLo = p[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (b == 0) begin
                    mLo = '1;
                    mHi = a;
                end else if (o == MD_DIV) begin
                    p = sa / sb;
                    mLo = p[31:0];
                    p = sa % sb;
                    mHi = p[31:0];
                end else begin
                    mLo = a / b;
                    mHi = a % b;
                end
            end
            MD_MTHI: mHi = a;
            MD_MTLO: mLo = a;
            default: ;
        endcase
    endtask

    // Present one op for a single clock edge, starting and ending #1 after a rising edge
    task automatic applyStimulus(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        op       = o;
        Data1    = a;
        Data2    = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = MD_NONE;
    endtask

    // Full mult/div transaction: check latency, done pulse and committed HI/LO
    task automatic runOp(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int cyc;
        applyStimulus(o, a, b);
        checkOutput({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        modelOp(o, a, b);
        checkOutput({tag, "_cycles"}, cyc, W);
        checkOutput({tag, "_doneBusy"}, busy, 0);
        checkOutput({tag, "_hi"}, HI, mHi);
        checkOutput({tag, "_lo"}, LO, mLo);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, done, 0);
    endtask

    // Move to HI/LO: committed at the next edge without busy or done
    task automatic moveOp(input md_op_t o, input logic [W-1:0] a, input string tag);
        applyStimulus(o, a, '0);
        modelOp(o, a, '0);
        checkOutput({tag, "_hi"}, HI, mHi);
        checkOutput({tag, "_lo"}, LO, mLo);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_ready"}, op_ready, 1);
    endtask

    int           doneSeen;
    int           pick;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    md_op_t       rop;

    initial begin
        // Reset state
        #2;
        checkOutput("rst_hi", HI, 0);
        checkOutput("rst_lo", LO, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", op_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Datasheet multiply and divide examples
        runOp(MD_MULT,  32'hFFFFFFFD, 32'h00000005, "multNeg");
        runOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multuMax");
        runOp(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, "multMinus1");
        runOp(MD_DIV,   32'hFFFFFFF9, 32'h00000002, "divNeg");
        runOp(MD_DIV,   32'h80000000, 32'hFFFFFFFF, "divMinOvf");
        runOp(MD_DIVU,  32'h00000007, 32'h00000000, "divuZero");
`ifdef MULDIV_DIV0_FLAG_EN
        checkOutput("div0_afterDone", div0, 1);
`endif
        runOp(MD_DIV,   32'hFFFFFF00, 32'h00000000, "divZeroNeg");
        runOp(MD_DIV,   32'h00000064, 32'hFFFFFFF9, "divNegDivisor");

        // MTHI, then a DIV that is flushed while a MULTU is offered during busy
        moveOp(MD_MTHI, 32'h12345678, "mthi");
        applyStimulus(MD_DIV, 32'h00001000, 32'h00000003);
        op       = MD_MULTU;
        Data1    = 32'd2;
        Data2    = 32'd3;
        op_valid = 1'b1;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busyIgnore_ready", op_ready, 0);
        op_valid = 1'b0;
        op       = MD_NONE;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_ready", op_ready, 1);
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) doneSeen++;
            @(posedge clk);
            #1;
        end
        checkOutput("flush_noDone", doneSeen, 0);
        checkOutput("flush_hi", HI, 32'h12345678);
        checkOutput("flush_lo", LO, mLo);

        // Flush in IDLE wins over a simultaneous op
        op       = MD_MULT;
        Data1    = 32'd9;
        Data2    = 32'd9;
        op_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        op       = MD_NONE;
        checkOutput("idleFlush_busy", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("idleFlush_done", done, 0);
        checkOutput("idleFlush_lo", LO, mLo);

        // Asynchronous reset in the middle of a MULT
        applyStimulus(MD_MULT, 32'h00000123, 32'h00000456);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        mHi = '0;
        mLo = '0;
        checkOutput("asyncRst_hi", HI, 0);
        checkOutput("asyncRst_lo", LO, 0);
        checkOutput("asyncRst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        moveOp(MD_MTLO, 32'hAAAA5555, "mtloAfterRst");

        // Randomized traffic against the model
        for (int n = 0; n < 24; n++) begin
            pick = $urandom_range(0, 11);
            ra = $urandom;
            rb = $urandom;
            rop = md_op_t'(3'($urandom_range(1, 4)));
            if (pick == 0) rb = '0;
            if (pick == 1) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
                rop = MD_DIV;
            end
            if (pick == 2) rb = rb >> $urandom_range(8, 28);
            if (pick == 10) moveOp(MD_MTHI, ra, "rndMthi");
            else if (pick == 11) moveOp(MD_MTLO, ra, "rndMtlo");
            else runOp(rop, ra, rb, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
